// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the RV32I register file with busy scoreboard.
package reg_file_sb_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned NUM_RD_DEF = 2;
    localparam int unsigned BYPASS_DEF = 1;
    // Architectural zero register index.
    localparam int unsigned X0         = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for in-flight producers; feeds RAW hazard detection in decode.
module rf_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_RD*AW-1:0] i_RA,
    output logic [NUM_RD-1:0]    o_BUSY,
    input  logic                 i_WE,
    input  logic [AW-1:0]        i_WA,
    input  logic                 i_ISSUE,
    input  logic [AW-1:0]        i_ISSUE_RD,
    output logic                 o_ANY_BUSY
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy vector: a new issue beats a completing write to the same register.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (i_ISSUE && (i_ISSUE_RD == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (i_WE && (i_WA == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[X0] = 1'b0;
    end

    // Busy state register; reset drops all pending producers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Busy lookup per read port comes from registered state only.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
        assign o_BUSY[p] = !i_rst && busy_q[i_RA[p*AW +: AW]];
    end

    assign o_ANY_BUSY = !i_rst && (|busy_q);

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with x0 hardwired to zero, optional write bypass and busy scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF,
    parameter int unsigned BYPASS = BYPASS_DEF,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_RD*AW-1:0]   i_RA,
    output logic [NUM_RD*XLEN-1:0] o_RD,
    output logic [NUM_RD-1:0]      o_BUSY,
    input  logic                   i_WE,
    input  logic [AW-1:0]          i_WA,
    input  logic [XLEN-1:0]        i_WD,
    input  logic                   i_ISSUE,
    input  logic [AW-1:0]          i_ISSUE_RD,
    output logic                   o_ANY_BUSY
);

    logic [XLEN-1:0] xreg_q [NREGS];
    logic            write_en_c;

    // Writes targeting x0 are dropped here so they neither store nor bypass.
    assign write_en_c = i_WE && (i_WA != AW'(X0));

    // Data array update; entry 0 is never written and stays zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                xreg_q[r] <= '0;
            end
        end else if (write_en_c) begin
            xreg_q[i_WA] <= i_WD;
        end
    end

    // Combinational read ports with optional same-cycle write forwarding.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]   ra_c;
        logic [XLEN-1:0] rd_c;

        assign ra_c = i_RA[p*AW +: AW];

        // Select stored value, forwarded write data, or forced zero.
        always_comb begin
            rd_c = xreg_q[ra_c];
            if ((BYPASS != 0) && write_en_c && (i_WA == ra_c)) begin
                rd_c = i_WD;
            end
            if (i_rst || (ra_c == AW'(X0))) begin
                rd_c = '0;
            end
        end

        assign o_RD[p*XLEN +: XLEN] = rd_c;
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .AW     (AW)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_RA       (i_RA),
        .o_BUSY     (o_BUSY),
        .i_WE       (i_WE),
        .i_WA       (i_WA),
        .i_ISSUE    (i_ISSUE),
        .i_ISSUE_RD (i_ISSUE_RD),
        .o_ANY_BUSY (o_ANY_BUSY)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two configurations (32x32, 3 ports, bypass) and (64x16, 2 ports, no bypass).
module tb_reg_file_sb;

    localparam int unsigned AXL = 32;
    localparam int unsigned AN  = 32;
    localparam int unsigned ARD = 3;
    localparam int unsigned AAW = 5;
    localparam int unsigned BXL = 64;
    localparam int unsigned BN  = 16;
    localparam int unsigned BRD = 2;
    localparam int unsigned BAW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [ARD*AAW-1:0] a_ra;
    logic [ARD*AXL-1:0] a_rd;
    logic [ARD-1:0]     a_busy;
    logic               a_we;
    logic [AAW-1:0]     a_wa;
    logic [AXL-1:0]     a_wd;
    logic               a_iss;
    logic [AAW-1:0]     a_ird;
    logic               a_any;

    logic [BRD*BAW-1:0] b_ra;
    logic [BRD*BXL-1:0] b_rd;
    logic [BRD-1:0]     b_busy;
    logic               b_we;
    logic [BAW-1:0]     b_wa;
    logic [BXL-1:0]     b_wd;
    logic               b_iss;
    logic [BAW-1:0]     b_ird;
    logic               b_any;

    reg_file_sb #(.XLEN(AXL), .NREGS(AN), .NUM_RD(ARD), .BYPASS(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_RA(a_ra), .o_RD(a_rd), .o_BUSY(a_busy),
        .i_WE(a_we), .i_WA(a_wa), .i_WD(a_wd), .i_ISSUE(a_iss), .i_ISSUE_RD(a_ird),
        .o_ANY_BUSY(a_any)
    );

    reg_file_sb #(.XLEN(BXL), .NREGS(BN), .NUM_RD(BRD), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_RA(b_ra), .o_RD(b_rd), .o_BUSY(b_busy),
        .i_WE(b_we), .i_WA(b_wa), .i_WD(b_wd), .i_ISSUE(b_iss), .i_ISSUE_RD(b_ird),
        .o_ANY_BUSY(b_any)
    );

    // Reference model: architectural register contents and pending-producer flags.
    logic [AXL-1:0] ma_reg  [AN];
    logic           ma_busy [AN];
    logic [BXL-1:0] mb_reg  [BN];
    logic           mb_busy [BN];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [AXL-1:0] exp_a_rd(int p);
        logic [AAW-1:0] ra = a_ra[p*AAW +: AAW];
        if (rst || ra == '0) return '0;
        if (a_we && a_wa == ra) return a_wd;
        return ma_reg[ra];
    endfunction

    function automatic logic exp_a_busy(int p);
        logic [AAW-1:0] ra = a_ra[p*AAW +: AAW];
        if (rst || ra == '0) return 1'b0;
        return ma_busy[ra];
    endfunction

    function automatic logic exp_a_any();
        logic any = 1'b0;
        for (int r = 0; r < AN; r++) any = any | ma_busy[r];
        return any & !rst;
    endfunction

    function automatic logic [BXL-1:0] exp_b_rd(int p);
        logic [BAW-1:0] ra = b_ra[p*BAW +: BAW];
        if (rst || ra == '0) return '0;
        return mb_reg[ra];
    endfunction

    function automatic logic exp_b_busy(int p);
        logic [BAW-1:0] ra = b_ra[p*BAW +: BAW];
        if (rst || ra == '0) return 1'b0;
        return mb_busy[ra];
    endfunction

    function automatic logic exp_b_any();
        logic any = 1'b0;
        for (int r = 0; r < BN; r++) any = any | mb_busy[r];
        return any & !rst;
    endfunction

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < AN; r++) begin ma_reg[r] = '0; ma_busy[r] = 1'b0; end
            for (int r = 0; r < BN; r++) begin mb_reg[r] = '0; mb_busy[r] = 1'b0; end
        end else begin
            if (a_we && a_wa != '0) begin ma_reg[a_wa] = a_wd; ma_busy[a_wa] = 1'b0; end
            if (a_iss && a_ird != '0) ma_busy[a_ird] = 1'b1;
            if (b_we && b_wa != '0) begin mb_reg[b_wa] = b_wd; mb_busy[b_wa] = 1'b0; end
            if (b_iss && b_ird != '0) mb_busy[b_ird] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        a_we = 1'b0; a_wa = '0; a_wd = '0; a_iss = 1'b0; a_ird = '0; a_ra = '0;
        b_we = 1'b0; b_wa = '0; b_wd = '0; b_iss = 1'b0; b_ird = '0; b_ra = '0;
    endtask

    task automatic test_reset();
        for (int r = 1; r < AN; r++) begin
            a_we = 1'b1; a_wa = AAW'(r); a_wd = $urandom; a_iss = 1'b1; a_ird = AAW'(r);
            if (r < BN) begin
                b_we = 1'b1; b_wa = BAW'(r); b_wd = {$urandom, $urandom};
                b_iss = 1'b1; b_ird = BAW'(r);
            end else begin
                b_we = 1'b0; b_iss = 1'b0;
            end
            tick();
        end
        idle();
        #1;
        n_cmp++;
        if (a_any !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_any: got %b want 1", a_any);
        end
        rst = 1'b1;
        a_ra = {AAW'(9), AAW'(3), AAW'(31)};
        b_ra = {BAW'(15), BAW'(2)};
        #1;
        for (int p = 0; p < ARD; p++) begin
            n_cmp++;
            if (a_rd[p*AXL +: AXL] !== '0 || a_busy[p] !== 1'b0) begin
                n_err++; $display("FAIL reset_during_a p%0d: rd=%h busy=%b want 0/0", p, a_rd[p*AXL +: AXL], a_busy[p]);
            end
        end
        n_cmp++;
        if (a_any !== 1'b0 || b_any !== 1'b0 || b_rd !== '0) begin
            n_err++; $display("FAIL reset_during_any: a_any=%b b_any=%b b_rd=%h want 0", a_any, b_any, b_rd);
        end
        tick();
        rst = 1'b0;
        for (int r = 0; r < AN; r++) begin
            a_ra = {3{AAW'(r)}};
            b_ra = {2{BAW'(r % BN)}};
            #1;
            n_cmp++;
            if (a_rd !== '0 || a_busy !== '0 || a_any !== 1'b0) begin
                n_err++; $display("FAIL reset_after_a x%0d: rd=%h busy=%b any=%b want 0", r, a_rd, a_busy, a_any);
            end
            n_cmp++;
            if (b_rd !== '0 || b_busy !== '0 || b_any !== 1'b0) begin
                n_err++; $display("FAIL reset_after_b x%0d: rd=%h busy=%b any=%b want 0", r % BN, b_rd, b_busy, b_any);
            end
        end
    endtask

    task automatic test_x0();
        idle();
        a_we = 1'b1; a_wa = '0; a_wd = 32'hDEADBEEF; a_iss = 1'b1; a_ird = '0;
        b_we = 1'b1; b_wa = '0; b_wd = 64'hDEADBEEF; b_iss = 1'b1; b_ird = '0;
        #1;
        n_cmp++;
        if (a_rd[AXL-1:0] !== '0) begin
            n_err++; $display("FAIL x0_no_bypass: got %h want 0", a_rd[AXL-1:0]);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (a_rd[AXL-1:0] !== '0 || a_busy[0] !== 1'b0 || a_any !== 1'b0) begin
            n_err++; $display("FAIL x0_a: rd=%h busy=%b any=%b want 0/0/0", a_rd[AXL-1:0], a_busy[0], a_any);
        end
        n_cmp++;
        if (b_rd[BXL-1:0] !== '0 || b_busy[0] !== 1'b0 || b_any !== 1'b0) begin
            n_err++; $display("FAIL x0_b: rd=%h busy=%b any=%b want 0/0/0", b_rd[BXL-1:0], b_busy[0], b_any);
        end
    endtask

    task automatic test_bypass();
        idle();
        b_we = 1'b1; b_wa = BAW'(5); b_wd = 64'hAAAA;
        tick();
        idle();
        a_we = 1'b1; a_wa = AAW'(5); a_wd = 32'h1234; a_ra = {AAW'(0), AAW'(0), AAW'(5)};
        b_we = 1'b1; b_wa = BAW'(5); b_wd = 64'h1234; b_ra = {BAW'(0), BAW'(5)};
        #1;
        n_cmp++;
        if (a_rd[AXL-1:0] !== 32'h1234) begin
            n_err++; $display("FAIL bypass_on_same_cycle: got %h want 00001234", a_rd[AXL-1:0]);
        end
        n_cmp++;
        if (b_rd[BXL-1:0] !== 64'hAAAA) begin
            n_err++; $display("FAIL bypass_off_same_cycle: got %h want 000000000000aaaa", b_rd[BXL-1:0]);
        end
        tick();
        a_we = 1'b0; b_we = 1'b0;
        #1;
        n_cmp++;
        if (a_rd[AXL-1:0] !== 32'h1234) begin
            n_err++; $display("FAIL bypass_on_next: got %h want 00001234", a_rd[AXL-1:0]);
        end
        n_cmp++;
        if (b_rd[BXL-1:0] !== 64'h1234) begin
            n_err++; $display("FAIL bypass_off_next: got %h want 0000000000001234", b_rd[BXL-1:0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        a_iss = 1'b1; a_ird = AAW'(7); a_ra = {AAW'(9), AAW'(7), AAW'(7)};
        #1;
        n_cmp++;
        if (a_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL sb_issue_same_cycle: got %b want 0", a_busy[0]);
        end
        tick();
        a_iss = 1'b0;
        #1;
        n_cmp++;
        if (a_busy !== 3'b011 || a_any !== 1'b1) begin
            n_err++; $display("FAIL sb_issue_next: busy=%b any=%b want 011/1", a_busy, a_any);
        end
        a_we = 1'b1; a_wa = AAW'(7); a_wd = 32'h77;
        #1;
        n_cmp++;
        if (a_busy[0] !== 1'b1) begin
            n_err++; $display("FAIL sb_complete_same_cycle: got %b want 1", a_busy[0]);
        end
        tick();
        a_we = 1'b0;
        #1;
        n_cmp++;
        if (a_busy[0] !== 1'b0 || a_any !== 1'b0) begin
            n_err++; $display("FAIL sb_complete_next: busy=%b any=%b want 0/0", a_busy[0], a_any);
        end
        a_we = 1'b1; a_wa = AAW'(7); a_iss = 1'b1; a_ird = AAW'(7);
        tick();
        a_we = 1'b0; a_iss = 1'b0;
        #1;
        n_cmp++;
        if (a_busy[0] !== 1'b1) begin
            n_err++; $display("FAIL sb_issue_beats_complete: got %b want 1", a_busy[0]);
        end
        a_we = 1'b1; a_wa = AAW'(9); a_wd = 32'h99;
        tick();
        a_we = 1'b1; a_wa = AAW'(7);
        tick();
        a_we = 1'b0;
        #1;
        n_cmp++;
        if (a_busy !== 3'b000 || a_any !== 1'b0 || a_rd[2*AXL +: AXL] !== 32'h99) begin
            n_err++; $display("FAIL sb_nonbusy_write: busy=%b any=%b rd2=%h want 000/0/99", a_busy, a_any, a_rd[2*AXL +: AXL]);
        end
    endtask

    task automatic test_multiport();
        idle();
        for (int r = 1; r <= 3; r++) begin
            a_we = 1'b1; a_wa = AAW'(r); a_wd = AXL'(r * 10);
            tick();
        end
        idle();
        a_ra = {AAW'(3), AAW'(1), AAW'(3)};
        #1;
        n_cmp++;
        if (a_rd !== {32'd30, 32'd10, 32'd30}) begin
            n_err++; $display("FAIL multiport_data: got %h want 0000001e0000000a0000001e", a_rd);
        end
        a_iss = 1'b1; a_ird = AAW'(3);
        b_iss = 1'b1; b_ird = BAW'(6);
        tick();
        a_ird = AAW'(4);
        tick();
        a_iss = 1'b0; b_iss = 1'b0;
        a_ra = {AAW'(3), AAW'(4), AAW'(3)};
        b_ra = {BAW'(6), BAW'(6)};
        #1;
        n_cmp++;
        if (a_busy !== 3'b111 || a_any !== 1'b1 || b_busy !== 2'b11) begin
            n_err++; $display("FAIL multiport_busy: a_busy=%b a_any=%b b_busy=%b want 111/1/11", a_busy, a_any, b_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_busy !== 3'b000 || a_any !== 1'b0 || b_busy !== 2'b00 || b_any !== 1'b0) begin
            n_err++; $display("FAIL midreset_busy: a_busy=%b a_any=%b b_busy=%b b_any=%b want 0", a_busy, a_any, b_busy, b_any);
        end
    endtask

    task automatic test_soak();
        for (int c = 0; c < 1000; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            a_we  = 1'($urandom);
            a_iss = 1'($urandom);
            a_wd  = $urandom;
            a_wa  = ($urandom_range(0, 3) == 0) ? AAW'($urandom) : AAW'($urandom_range(0, 7));
            a_ird = ($urandom_range(0, 3) == 0) ? AAW'($urandom) : AAW'($urandom_range(0, 7));
            for (int p = 0; p < ARD; p++)
                a_ra[p*AAW +: AAW] = ($urandom_range(0, 3) == 0) ? AAW'($urandom) : AAW'($urandom_range(0, 7));
            b_we  = 1'($urandom);
            b_iss = 1'($urandom);
            b_wd  = {$urandom, $urandom};
            b_wa  = BAW'($urandom_range(0, 7));
            b_ird = BAW'($urandom_range(0, 7));
            for (int p = 0; p < BRD; p++) b_ra[p*BAW +: BAW] = BAW'($urandom_range(0, 7));
            #1;
            for (int p = 0; p < ARD; p++) begin
                n_cmp++;
                if (a_rd[p*AXL +: AXL] !== exp_a_rd(p) || a_busy[p] !== exp_a_busy(p)) begin
                    n_err++; $display("FAIL soak_a c%0d p%0d: rd=%h busy=%b want %h/%b", c, p, a_rd[p*AXL +: AXL], a_busy[p], exp_a_rd(p), exp_a_busy(p));
                end
            end
            for (int p = 0; p < BRD; p++) begin
                n_cmp++;
                if (b_rd[p*BXL +: BXL] !== exp_b_rd(p) || b_busy[p] !== exp_b_busy(p)) begin
                    n_err++; $display("FAIL soak_b c%0d p%0d: rd=%h busy=%b want %h/%b", c, p, b_rd[p*BXL +: BXL], b_busy[p], exp_b_rd(p), exp_b_busy(p));
                end
            end
            n_cmp++;
            if (a_any !== exp_a_any() || b_any !== exp_b_any()) begin
                n_err++; $display("FAIL soak_any c%0d: a=%b b=%b want %b/%b", c, a_any, b_any, exp_a_any(), exp_b_any());
            end
            tick();
        end
    endtask

    initial begin
        idle();
        for (int r = 0; r < AN; r++) begin ma_reg[r] = '0; ma_busy[r] = 1'b0; end
        for (int r = 0; r < BN; r++) begin mb_reg[r] = '0; mb_busy[r] = 1'b0; end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_multiport();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
